fetch_pc_unit: RTL



---
 rtl/fetch_pc_unit_pkg.sv | 20 ++
 rtl/fetch_predecode.sv | 23 ++
 rtl/fetch_pc_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage definitions: jump opcodes, state encoding, reset PC
// and the J/JAL target formation used by the pre-decoder.
package cpu_defs;

  localparam logic [5:0]  OPC_J            = 6'h02;
  localparam logic [5:0]  OPC_JAL          = 6'h03;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  // Region bits come from the sequential PC, not the jump's own PC.
  function automatic logic [31:0] jump_target(input logic [3:0]  pcPlus4Hi,
                                              input logic [25:0] instIndex);
    return {pcPlus4Hi, instIndex, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational pre-decode of the instruction currently on the ROM bus so
// unconditional jumps can steer the PC in the same cycle they are fetched.
module fetch_predecode
  import cpu_defs::*;
(
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic        o_is_jump,
  output logic        o_is_self_jump,
  output logic [31:0] o_jump_target,
  output logic [31:0] o_pc_plus4
);

  logic [5:0] w_opcode;

  assign w_opcode      = i_inst[31:26];
  assign o_pc_plus4    = i_pc + 32'd4;
  assign o_jump_target = jump_target(o_pc_plus4[31:28], i_inst[25:0]);
  assign o_is_jump     = (w_opcode == OPC_J) || (w_opcode == OPC_JAL);
  // Only a plain J to itself ends a program; a JAL to itself still links.
  assign o_is_self_jump = (w_opcode == OPC_J) && (o_jump_target == i_pc);

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, addresses the zero-latency ROM and
// registers the fetched instruction toward decode with a valid/ready handshake.
module fetch_pc_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  output logic [31:0]      o_rom_addr,
  input  logic [31:0]      i_rom_inst,
  input  logic             i_redirect_valid,
  input  logic [31:0]      i_redirect_target,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_inst,
  output logic [31:0]      o_out_pc,
  output logic [31:0]      o_out_pc_plus4,
  output logic             o_halted,
  output logic             o_align_err,
  output logic [CNT_W-1:0] o_fetch_count
);

  fetch_state_t     r_state;
  fetch_state_t     w_state_next;
  logic [31:0]      r_pc;
  logic             r_out_valid;
  logic [31:0]      r_out_inst;
  logic [31:0]      r_out_pc;
  logic [31:0]      r_out_pc_plus4;
  logic             r_align_err;
  logic [CNT_W-1:0] r_fetch_count;

  logic             w_slot_free;
  logic             w_fetch;
  logic             w_is_jump;
  logic             w_is_self_jump;
  logic [31:0]      w_jump_target;
  logic [31:0]      w_pc_plus4;

  fetch_predecode u_predecode (
    .i_inst         (i_rom_inst),
    .i_pc           (r_pc),
    .o_is_jump      (w_is_jump),
    .o_is_self_jump (w_is_self_jump),
    .o_jump_target  (w_jump_target),
    .o_pc_plus4     (w_pc_plus4)
  );

  assign w_slot_free = !r_out_valid || i_out_ready;
  assign w_fetch     = (r_state == ST_RUN) && w_slot_free && !i_redirect_valid;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= ST_RUN;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (i_redirect_valid)                  w_state_next = ST_RUN;
    else if (w_fetch && w_is_self_jump)    w_state_next = ST_HALT;
  end

  always_comb begin
    o_halted = (r_state == ST_HALT);
  end

  // A redirect flushes the output register even when decode is stalled.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_pc           <= RESET_PC;
      r_out_valid    <= 1'b0;
      r_out_inst     <= 32'd0;
      r_out_pc       <= 32'd0;
      r_out_pc_plus4 <= 32'd0;
      r_align_err    <= 1'b0;
      r_fetch_count  <= '0;
    end else if (i_redirect_valid) begin
      r_pc        <= {i_redirect_target[31:2], 2'b00};
      r_out_valid <= 1'b0;
      r_align_err <= |i_redirect_target[1:0];
    end else begin
      r_align_err <= 1'b0;
      if (w_fetch) begin
        r_out_valid    <= 1'b1;
        r_out_inst     <= i_rom_inst;
        r_out_pc       <= r_pc;
        r_out_pc_plus4 <= w_pc_plus4;
        r_fetch_count  <= r_fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
        // A self-jump target equals the current PC, so the PC holds on halt.
        r_pc           <= w_is_jump ? w_jump_target : w_pc_plus4;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_rom_addr     = r_pc;
  assign o_out_valid    = r_out_valid;
  assign o_out_inst     = r_out_inst;
  assign o_out_pc       = r_out_pc;
  assign o_out_pc_plus4 = r_out_pc_plus4;
  assign o_align_err    = r_align_err;
  assign o_fetch_count  = r_fetch_count;

endmodule
